// File: rtl/soc_interrupt_handler_pkg.sv
// Shared types and sizing helpers for the core-side SoC interrupt handler.
// Imported by the bus interface, the priority encoder and the handler FSM.
package soc_int_pkg;

    localparam int TAKEN_CNT_W = 16;
    localparam int HOLDOFF_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2,
        ST_HOLDOFF = 2'd3
    } int_hdl_state_t;

    // A single interrupt line still needs a one-bit cause field.
    function automatic int int_cause_w(input int num_ints);
        return (num_ints > 1) ? $clog2(num_ints) : 1;
    endfunction

    localparam int INT_CAUSE_W = int_cause_w(32);

endpackage

// File: rtl/soc_interrupt_handler_if.sv
// Interrupt bus between the SoC controller/core (master) and the handler (slave).
// Carries the pending vector, core status and the trap req/ack/mret handshake.
interface soc_interrupt_handler_if
    import soc_int_pkg::*;
#(
    parameter int NUM_INTS = 32
);

    localparam int CW = int_cause_w(NUM_INTS);

    logic [NUM_INTS-1:0]    int_pending;
    logic                   core_int_enable;
    logic                   core_halt;
    logic                   trap_req;
    logic [CW-1:0]          trap_cause;
    logic                   trap_ack;
    logic                   mret;
    logic                   in_service;
    logic [TAKEN_CNT_W-1:0] taken_count;

    modport master (
        output int_pending,
        output core_int_enable,
        output core_halt,
        output trap_ack,
        output mret,
        input  trap_req,
        input  trap_cause,
        input  in_service,
        input  taken_count
    );

    modport slave (
        input  int_pending,
        input  core_int_enable,
        input  core_halt,
        input  trap_ack,
        input  mret,
        output trap_req,
        output trap_cause,
        output in_service,
        output taken_count
    );

endinterface

// File: rtl/soc_interrupt_handler_prio_enc.sv
// Fixed-priority encoder: picks the lowest (PRIORITY_LSB=1) or highest set index.
// Purely combinational; valid_o flags that at least one line is pending.
module soc_int_priority_enc
    import soc_int_pkg::*;
#(
    parameter int NUM_INTS     = 32,
    parameter bit PRIORITY_LSB = 1'b1
) (
    input  logic [NUM_INTS-1:0]              vec_i,
    output logic [int_cause_w(NUM_INTS)-1:0] idx_o,
    output logic                             valid_o
);

    localparam int CW = int_cause_w(NUM_INTS);

    // Scan towards the winning end so the last hit overwrites earlier ones.
    always_comb begin
        idx_o   = '0;
        valid_o = |vec_i;
        if (PRIORITY_LSB) begin
            for (int i = NUM_INTS - 1; i >= 0; i--) begin
                if (vec_i[i]) begin
                    idx_o = CW'(i);
                end
            end
        end else begin
            for (int i = 0; i < NUM_INTS; i++) begin
                if (vec_i[i]) begin
                    idx_o = CW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/soc_interrupt_handler.sv
// Core-side interrupt endpoint: arbitrates the pending vector, runs the trap
// req/ack handshake and holds off re-entry for HOLDOFF_CYCLES after mret.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | waiting for an enabled pending line while MIE=1 and not halted
// ST_REQ     | trap_req raised, cause frozen until ack or withdraw
// ST_SERVICE | handler running, pending vector ignored until mret
// ST_HOLDOFF | post-mret quiet period so a late flag clear cannot re-trigger
module soc_interrupt_handler
    import soc_int_pkg::*;
#(
    parameter int NUM_INTS       = 32,
    parameter int HOLDOFF_CYCLES = 2,
    parameter bit PRIORITY_LSB   = 1'b1
) (
    input logic                     clk,
    input logic                     res,
    soc_interrupt_handler_if.slave  irq_bus
);

    localparam int                   CW        = int_cause_w(NUM_INTS);
    localparam logic [HOLDOFF_W-1:0] HOLD_INIT = HOLDOFF_W'(HOLDOFF_CYCLES);

    int_hdl_state_t         state_q, state_d;
    logic [CW-1:0]          cause_q, cause_d;
    logic [HOLDOFF_W-1:0]   hold_q, hold_d;
    logic [TAKEN_CNT_W-1:0] cnt_q, cnt_d;
    logic                   req_q;
    logic                   svc_q;

    logic [CW-1:0]          enc_idx;
    logic                   enc_valid;
    logic                   arb_ok;
    logic                   cause_pending;
    logic                   withdraw;

    soc_int_priority_enc #(
        .NUM_INTS     (NUM_INTS),
        .PRIORITY_LSB (PRIORITY_LSB)
    ) u_enc (
        .vec_i   (irq_bus.int_pending),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    assign arb_ok        = irq_bus.core_int_enable && !irq_bus.core_halt && enc_valid;
    assign cause_pending = irq_bus.int_pending[cause_q];
    assign withdraw      = !cause_pending || !irq_bus.core_int_enable || irq_bus.core_halt;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_ok) begin
                    state_d = ST_REQ;
                    cause_d = enc_idx;
                end
            end

            ST_REQ: begin
                // An ack in the same cycle as a withdraw condition still wins.
                if (irq_bus.trap_ack) begin
                    state_d = ST_SERVICE;
                    if (cnt_q != {TAKEN_CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (withdraw) begin
                    state_d = ST_IDLE;
                end
            end

            ST_SERVICE: begin
                if (irq_bus.mret) begin
                    if (HOLDOFF_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLDOFF;
                        hold_d  = HOLD_INIT;
                    end
                end
            end

            ST_HOLDOFF: begin
                // The final holdoff cycle doubles as the arbitration slot, so a
                // request appears HOLDOFF_CYCLES+1 cycles after mret.
                if (hold_q <= HOLDOFF_W'(1)) begin
                    hold_d = '0;
                    if (arb_ok) begin
                        state_d = ST_REQ;
                        cause_d = enc_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= ST_IDLE;
            cause_q <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            svc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            req_q   <= (state_d == ST_REQ);
            svc_q   <= (state_d == ST_SERVICE);
        end
    end

    assign irq_bus.trap_req    = req_q;
    assign irq_bus.trap_cause  = cause_q;
    assign irq_bus.in_service  = svc_q;
    assign irq_bus.taken_count = cnt_q;

endmodule

// File: tb/tb_soc_interrupt_handler.sv
// Bench for soc_interrupt_handler: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_soc_interrupt_handler;
    import soc_int_pkg::*;

    localparam int NI = 32;
    localparam int HC = 2;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_SVC  = 2;
    localparam int P_HOLD = 3;

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    soc_interrupt_handler_if #(.NUM_INTS(NI)) bus ();
    soc_interrupt_handler_if #(.NUM_INTS(NI)) bus_msb ();

    assign bus_msb.int_pending     = bus.int_pending;
    assign bus_msb.core_int_enable = bus.core_int_enable;
    assign bus_msb.core_halt       = bus.core_halt;
    assign bus_msb.trap_ack        = bus.trap_ack;
    assign bus_msb.mret            = bus.mret;

    soc_interrupt_handler #(
        .NUM_INTS(NI), .HOLDOFF_CYCLES(HC), .PRIORITY_LSB(1'b1)
    ) u_dut (
        .clk(clk), .res(res), .irq_bus(bus)
    );

    soc_interrupt_handler #(
        .NUM_INTS(NI), .HOLDOFF_CYCLES(HC), .PRIORITY_LSB(1'b0)
    ) u_dut_msb (
        .clk(clk), .res(res), .irq_bus(bus_msb)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the handler must be doing after each clock edge.
    int  m_phase;
    int  m_cause;
    int  m_count;
    int  m_left;
    bit  m_valid = 1'b0;

    function automatic int lowest_set(input logic [NI-1:0] v);
        for (int i = 0; i < NI; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit may_raise();
        return bus.core_int_enable && !bus.core_halt && (bus.int_pending != '0);
    endfunction

    always @(posedge clk) begin
        if (res) begin
            m_phase = P_IDLE;
            m_cause = 0;
            m_count = 0;
            m_left  = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            case (m_phase)
                P_IDLE: begin
                    if (may_raise()) begin
                        m_phase = P_REQ;
                        m_cause = lowest_set(bus.int_pending);
                    end
                end
                P_REQ: begin
                    if (bus.trap_ack) begin
                        m_phase = P_SVC;
                        m_count = (m_count < 65535) ? m_count + 1 : 65535;
                    end else if (!bus.int_pending[m_cause] || !bus.core_int_enable || bus.core_halt) begin
                        m_phase = P_IDLE;
                    end
                end
                P_SVC: begin
                    if (bus.mret) begin
                        if (HC == 0) begin
                            m_phase = P_IDLE;
                        end else begin
                            m_phase = P_HOLD;
                            m_left  = HC;
                        end
                    end
                end
                default: begin
                    if (m_left == 1) begin
                        m_left = 0;
                        if (may_raise()) begin
                            m_phase = P_REQ;
                            m_cause = lowest_set(bus.int_pending);
                        end else begin
                            m_phase = P_IDLE;
                        end
                    end else begin
                        m_left = m_left - 1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_trap_req",   32'(bus.trap_req),    32'(m_phase == P_REQ));
            check("model_in_service", 32'(bus.in_service),  32'(m_phase == P_SVC));
            check("model_trap_cause", 32'(bus.trap_cause),  32'(m_cause));
            check("model_taken_cnt",  32'(bus.taken_count), 32'(m_count));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(bus.trap_req),    32'd0);
        check({tag, "_cause"}, 32'(bus.trap_cause),  32'd0);
        check({tag, "_svc"},   32'(bus.in_service),  32'd0);
        check({tag, "_cnt"},   32'(bus.taken_count), 32'd0);
    endtask

    logic [NI-1:0] rnd_pend;

    initial begin
        res                 = 1'b1;
        bus.int_pending     = '0;
        bus.core_int_enable = 1'b0;
        bus.core_halt       = 1'b0;
        bus.trap_ack        = 1'b0;
        bus.mret            = 1'b0;
        tick();
        tick();
        res = 1'b0;
        check_reset_outputs("reset");

        // Lowest set bit wins; the MSB-priority twin picks the highest.
        bus.int_pending     = 32'h0000_0030;
        bus.core_int_enable = 1'b1;
        tick();
        check("t1_req",       32'(bus.trap_req),       32'd1);
        check("t1_cause",     32'(bus.trap_cause),     32'd4);
        check("t1_cause_msb", 32'(bus_msb.trap_cause), 32'd5);

        bus.int_pending = 32'h0000_0020;
        tick();
        check("t2_withdraw_req", 32'(bus.trap_req),    32'd0);
        check("t2_withdraw_cnt", 32'(bus.taken_count), 32'd0);
        tick();
        check("t2_rearb_cause",  32'(bus.trap_cause),  32'd5);
        bus.int_pending = 32'h0;
        bus.trap_ack    = 1'b1;
        tick();
        bus.trap_ack = 1'b0;
        check("t2_ackwin_svc", 32'(bus.in_service),  32'd1);
        check("t2_ackwin_cnt", 32'(bus.taken_count), 32'd1);

        bus.int_pending = 32'h1;
        tick();
        tick();
        check("t3_svc_holds", 32'(bus.trap_req), 32'd0);
        bus.mret = 1'b1;
        tick();
        bus.mret = 1'b0;
        check("t3_hold1_req", 32'(bus.trap_req),   32'd0);
        check("t3_hold1_svc", 32'(bus.in_service), 32'd0);
        tick();
        check("t3_hold2_req", 32'(bus.trap_req), 32'd0);
        tick();
        check("t3_third_req",   32'(bus.trap_req),   32'd1);
        check("t3_third_cause", 32'(bus.trap_cause), 32'd0);

        bus.mret = 1'b1;
        tick();
        bus.mret = 1'b0;
        check("t5_mret_in_req", 32'(bus.trap_req),    32'd1);
        check("t5_mret_in_cnt", 32'(bus.taken_count), 32'd1);
        bus.trap_ack = 1'b1;
        tick();
        bus.trap_ack = 1'b0;
        bus.mret     = 1'b1;
        tick();
        bus.mret        = 1'b0;
        bus.int_pending = '0;
        tick();
        tick();
        bus.trap_ack = 1'b1;
        tick();
        bus.trap_ack = 1'b0;
        check("t5_stray_ack_req", 32'(bus.trap_req),    32'd0);
        check("t5_stray_ack_cnt", 32'(bus.taken_count), 32'd2);

        bus.int_pending     = 32'hFFFF_FFFF;
        bus.core_int_enable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                bus.core_int_enable = 1'b1;
                bus.core_halt       = 1'b1;
            end
            tick();
            check("t4_blocked_req", 32'(bus.trap_req), 32'd0);
        end
        bus.core_halt = 1'b0;
        tick();
        check("t4_unblock_req",   32'(bus.trap_req),   32'd1);
        check("t4_unblock_cause", 32'(bus.trap_cause), 32'd0);

        bus.trap_ack = 1'b1;
        tick();
        bus.trap_ack = 1'b0;
        check("t5_pre_reset_svc", 32'(bus.in_service), 32'd1);
        res = 1'b1;
        tick();
        res = 1'b0;
        check_reset_outputs("t5_reset_in_svc");

        // Preload the counter near the top so saturation is reached in a few traps.
        bus.int_pending = 32'h1;
        force u_dut.cnt_q = 16'hFFF8;
        m_count = 32'hFFF8;
        tick();
        release u_dut.cnt_q;
        for (int i = 0; i < 150; i++) begin
            bus.trap_ack = bus.trap_req;
            bus.mret     = bus.in_service;
            tick();
        end
        bus.trap_ack = 1'b0;
        bus.mret     = 1'b0;
        check("t6_saturated", 32'(bus.taken_count), 32'h0000_FFFF);

        res = 1'b1;
        tick();
        res = 1'b0;
        rnd_pend = '0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       rnd_pend = '0;
                    1:       rnd_pend = NI'($urandom);
                    default: rnd_pend = NI'(1) << $urandom_range(0, NI - 1);
                endcase
            end
            bus.int_pending     = rnd_pend;
            bus.core_int_enable = ($urandom_range(0, 9) != 0);
            bus.core_halt       = ($urandom_range(0, 19) == 0);
            bus.trap_ack        = ($urandom_range(0, 2) == 0);
            bus.mret            = ($urandom_range(0, 3) == 0);
            res                 = ($urandom_range(0, 299) == 0);
            tick();
        end
        res          = 1'b0;
        bus.trap_ack = 1'b0;
        bus.mret     = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
